// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle processor main control FSM (Moore)
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       branch,
  output logic       pc_update,
  output logic       reg_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t cur_state;
  state_t next_state;

  assign state = cur_state;

  // State register; reset drops straight back to FETCH without a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state selection; unknown opcodes and unused codes fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (cur_state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  // Datapath controls decode from state alone; illegal also looks at op in DECODE
  always_comb begin
    branch     = 1'b0;
    pc_update  = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (cur_state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = !(op == OP_LW || op == OP_SW || op == OP_R ||
                      op == OP_I || op == OP_BEQ || op == OP_JAL);
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - directed table-driven bench for main_fsm
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       branch;
  logic       pc_update;
  logic       reg_write;
  logic       mem_write;
  logic       ir_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       illegal;

  main_fsm dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .branch(branch),
    .pc_update(pc_update),
    .reg_write(reg_write),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .adr_src(adr_src),
    .result_src(result_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .state(state),
    .illegal(illegal)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0110111;

  // one row: optional reset pulse or one clock edge, then expected state/outputs
  typedef struct {
    logic       do_reset;
    logic [6:0] op;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] out_tab[11];
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {branch, pc_update, reg_write, mem_write, ir_write, adr_src, result_src, alu_src_a, alu_src_b, alu_op}
  function automatic logic [13:0] act_out();
    return {branch, pc_update, reg_write, mem_write, ir_write, adr_src,
            result_src, alu_src_a, alu_src_b, alu_op};
  endfunction

  task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] o, input logic [3:0] s, input logic i);
    vec_t v;
    v.do_reset = r;
    v.op       = o;
    v.st       = s;
    v.ill      = i;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    op    = LW;

    out_tab[0]  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
    out_tab[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
    out_tab[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
    out_tab[3]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    out_tab[4]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
    out_tab[5]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    out_tab[6]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
    out_tab[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
    out_tab[8]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    out_tab[9]  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
    out_tab[10] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00};

    // lw
    add(1, LW, 0, 0); add(0, LW, 1, 0); add(0, LW, 2, 0); add(0, LW, 3, 0);
    add(0, LW, 4, 0); add(0, LW, 0, 0);
    // sw
    add(0, SW, 1, 0); add(0, SW, 2, 0); add(0, SW, 5, 0); add(0, SW, 0, 0);
    // R-type
    add(0, RT, 1, 0); add(0, RT, 6, 0); add(0, RT, 8, 0); add(0, RT, 0, 0);
    // I-ALU
    add(0, IT, 1, 0); add(0, IT, 7, 0); add(0, IT, 8, 0); add(0, IT, 0, 0);
    // jal
    add(0, JL, 1, 0); add(0, JL, 10, 0); add(0, JL, 8, 0); add(0, JL, 0, 0);
    // beq
    add(0, BQ, 1, 0); add(0, BQ, 9, 0); add(0, BQ, 0, 0);
    // illegal opcode: flag only in DECODE
    add(0, BAD, 1, 1); add(0, BAD, 0, 0); add(0, BAD, 1, 1); add(0, BAD, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op;
      if (vecs[i].do_reset) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      check("state", i, {12'd0, state}, {12'd0, vecs[i].st});
      check("outputs", i, {2'b00, act_out()}, {2'b00, out_tab[vecs[i].st]});
      check("illegal", i, {15'd0, illegal}, {15'd0, vecs[i].ill});
    end

    // async reset during MEMREAD of a lw
    op = LW;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pre_state", 100, {12'd0, state}, 16'd3);
    #2 reset = 1'b1;
    #1;
    check("rst_async_state", 101, {12'd0, state}, 16'd0);
    check("rst_async_writes", 102, {14'd0, reg_write, mem_write}, 16'd0);
    check("rst_async_ill", 103, {15'd0, illegal}, 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 104, {12'd0, state}, 16'd0);
    check("rst_hold_writes", 105, {14'd0, reg_write, mem_write}, 16'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_state", 106, {12'd0, state}, 16'd1);

    // async reset during MEMADR of a sw: MEMWRITE must never appear
    op = SW;
    @(posedge clk);
    @(negedge clk);
    check("sw_pre_state", 107, {12'd0, state}, 16'd2);
    #1 reset = 1'b1;
    #1;
    check("sw_rst_state", 108, {12'd0, state}, 16'd0);
    check("sw_rst_mem_write", 109, {15'd0, mem_write}, 16'd0);
    @(posedge clk);
    #1;
    check("sw_rst_hold_mem_write", 110, {15'd0, mem_write}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("sw_release_state", 111, {12'd0, state}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the state to FETCH immediately.
- op  in  7  opcode field from the instruction register.
- branch  out  1  conditional-branch enable for PC logic.
- pc_update  out  1  unconditional PC write enable.
- reg_write  out  1  register-file write enable.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction-register write enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- result_src  out  2  result mux select: 00 = ALU result register, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- alu_src_b  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_op  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = decode from funct3/funct7.
- state  out  4  current state encoding, for debug and verification.
- illegal  out  1  one-cycle flag indicating an unsupported opcode was decoded.

Function
REQ-002 The block SHALL be a Moore FSM. The state register is 4 bits. All outputs except `illegal` SHALL decode only from `state`.
REQ-003 State encodings SHALL be:

| State | Code |
|---|---|
| FETCH | 0 |
| DECODE | 1 |
| MEMADR | 2 |
| MEMREAD | 3 |
| MEMWB | 4 |
| MEMWRITE | 5 |
| EXECUTER | 6 |
| EXECUTEI | 7 |
| ALUWB | 8 |
| BEQ | 9 |
| JAL | 10 |

Codes 11–15 are unused.

REQ-004 Transitions from DECODE on `op`:
- 0000011 (lw) → MEMADR
- 0100011 (sw) → MEMADR
- 0110011 (R) → EXECUTER
- 0010011 (I-ALU) → EXECUTEI
- 1100011 (beq) → BEQ
- 1101111 (jal) → JAL
- any other opcode → FETCH

REQ-005 Transitions out of MEMADR: lw → MEMREAD, otherwise → MEMWRITE.
REQ-006 Fixed transitions: FETCH → DECODE; MEMREAD → MEMWB; EXECUTER → ALUWB; EXECUTEI → ALUWB; JAL → ALUWB.
REQ-007 MEMWB, MEMWRITE, ALUWB and BEQ SHALL all transition to FETCH.
REQ-008 Any unused code (11–15) SHALL transition to FETCH on the next edge.
REQ-009 Every output not listed for a state in REQ-010 through REQ-020 SHALL be 0 in that state.
REQ-010 FETCH outputs: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
REQ-011 DECODE outputs: alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch target.
REQ-012 MEMADR outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
REQ-013 MEMREAD outputs: result_src=00, adr_src=1.
REQ-014 MEMWB outputs: result_src=01, reg_write=1.
REQ-015 MEMWRITE outputs: result_src=00, adr_src=1, mem_write=1.
REQ-016 EXECUTER outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
REQ-017 EXECUTEI outputs: alu_src_a=10, alu_src_b=01, alu_op=10.
REQ-018 ALUWB outputs: result_src=00, reg_write=1.
REQ-019 BEQ outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
REQ-020 JAL outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
REQ-021 `illegal` SHALL be 1 exactly when state=DECODE and `op` is not listed in REQ-004; otherwise 0.
REQ-022 Per-instruction latencies, in cycles from FETCH to the next FETCH: lw=5, sw=4, R=4, I=4, jal=4, beq=3, illegal=2.
REQ-023 At most one of reg_write, mem_write and ir_write SHALL be 1 in any state.

Reset
REQ-024 Asserting `reset` SHALL set state=FETCH asynchronously, without waiting for a clock edge. Outputs then show FETCH values and `illegal`=0.
REQ-025 Asserting `reset` mid-instruction SHALL abandon the instruction, with no further reg_write or mem_write pulses. After release, the first rising edge SHALL move FETCH → DECODE.

Verification
REQ-026 The bench SHALL cover these scenarios:
- lw: reset, then op=0000011 → states 0,1,2,3,4,0; reg_write=1 only in state 4, with result_src=01.
- sw: op=0100011 → states 0,1,2,5,0; mem_write=1 only in state 5, with adr_src=1.
- R, I-ALU and jal: op=0110011 → 0,1,6,8,0; op=0010011 → 0,1,7,8,0; op=1101111 → 0,1,10,8,0. In state 10: pc_update=1 and alu_src_b=10.
- beq: op=1100011 → 0,1,9,0; in state 9: branch=1, alu_op=01, pc_update=0.
- Illegal opcode: op=0110111 → 0,1,0; illegal=1 only during state 1; no write enables asserted.
- Asynchronous reset mid-instruction: assert reset between edges while state=3 → state=0 immediately, before the next edge; mem_write and reg_write stay 0; after release → state 1 on the next edge.
